rf_wb_scheduler: RTL and testbench

Controller in front of the 32x32 register file (3 read ports, 1 write port, x0 hardwired to zero, write-through bypass).
- Shares the single write port between two sources: the in-order pipeline writeback (A) and the long-latency unit writeback (B, e.g. divider or memory).
- Keeps a busy scoreboard for registers awaiting B results and stalls issue on RAW/WAW hazards.
- Sits between the ID/WB stages, the long-latency unit and the register file.

---
 rtl/rf_wb_scheduler.sv | 86 ++++++++
 tb/tb_rf_wb_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates the RF write port between pipeline (A) and long-latency (B) writebacks, with a busy scoreboard.
// Ports: issue_* (ID hazard check, issue_stall out), wba_* / pipe_hold (source A), wbb_* / wbb_ready (source B),
// rf_we/rf_wa/rf_wd (register file write port), busy_vec (registers pending on B).
// Optional RF_WB_PERF_EN adds saturating hold_cnt / stall_cnt event counters.
module rf_wb_scheduler #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_long,
  output logic        issue_stall,
  input  logic        wba_valid,
  input  logic [4:0]  wba_addr,
  input  logic [31:0] wba_data,
  output logic        pipe_hold,
  input  logic        wbb_valid,
  input  logic [4:0]  wbb_addr,
  input  logic [31:0] wbb_data,
  output logic        wbb_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] busy_vec
`ifdef RF_WB_PERF_EN
  ,
  output logic [31:0] hold_cnt,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic {A_PRI, B_FORCE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] cnt_inc;
  logic [31:0] busy_q, busy_d, clr, eff, set;
  logic gnt_a, gnt_b, starve;
  always_comb begin
    gnt_b = wbb_valid & (state_q == B_FORCE | ~wba_valid);
    gnt_a = wba_valid & ~gnt_b;
    starve = wbb_valid & ~gnt_b;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    cnt_d = starve ? cnt_inc[CNT_W-1:0] : '0;
    // B_FORCE always lasts one cycle: B is either granted or has withdrawn
    state_d = (state_q == A_PRI && starve && cnt_inc == (CNT_W+1)'(STARVE_LIMIT)) ? B_FORCE : A_PRI;
    clr = gnt_b ? (32'd1 << wbb_addr) : '0;
    eff = busy_q & ~clr;
    issue_stall = ~rst & issue_valid & (eff[issue_rs1] | eff[issue_rs2] | eff[issue_rd]);
    set = (issue_valid & ~issue_stall & issue_long & issue_rd != 5'd0) ? (32'd1 << issue_rd) : '0;
    busy_d = (eff | set) & ~32'd1;
    rf_we = ~rst & (gnt_a | gnt_b);
    rf_wa = gnt_b ? wbb_addr : wba_addr;
    rf_wd = gnt_b ? wbb_data : wba_data;
    wbb_ready = ~rst & gnt_b;
    pipe_hold = ~rst & wba_valid & ~gnt_a;
    busy_vec = busy_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_PRI;
      cnt_q <= '0;
      busy_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
`ifdef RF_WB_PERF_EN
  logic [31:0] hold_q, stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      stall_q <= '0;
    end else begin
      hold_q <= hold_q + 32'(pipe_hold & ~&hold_q);
      stall_q <= stall_q + 32'(issue_stall & ~&stall_q);
    end
  end
  assign hold_cnt = hold_q;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed table, starvation sequence and random stimulus against a set-based reference model.
module tb_rf_wb_scheduler;
  localparam int LIMIT = 8;
  logic clk = 0, rst = 1;
  logic issue_valid = 0, issue_long = 0, wba_valid = 0, wbb_valid = 0;
  logic [4:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wba_addr = 0, wbb_addr = 0;
  logic [31:0] wba_data = 0, wbb_data = 0;
  logic issue_stall, pipe_hold, wbb_ready, rf_we;
  logic [4:0] rf_wa;
  logic [31:0] rf_wd, busy_vec;
`ifdef RF_WB_PERF_EN
  logic [31:0] hold_cnt, stall_cnt;
`endif
  int checks = 0, failures = 0;
  bit [31:0] mb;
  int waited, hc, sc;
  bit eb, ea, st, hold;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_long(issue_long), .issue_stall(issue_stall),
    .wba_valid(wba_valid), .wba_addr(wba_addr), .wba_data(wba_data), .pipe_hold(pipe_hold),
    .wbb_valid(wbb_valid), .wbb_addr(wbb_addr), .wbb_data(wbb_data), .wbb_ready(wbb_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy_vec(busy_vec)
`ifdef RF_WB_PERF_EN
    , .hold_cnt(hold_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic rst, iv;
    logic [4:0] rs1, rs2, rd;
    logic il, av;
    logic [4:0] aa;
    logic [31:0] ad;
    logic bv;
    logic [4:0] ba;
    logic [31:0] bd;
    logic e_we;
    logic [4:0] e_wa;
    logic [31:0] e_wd;
    logic e_rdy, e_hold, e_stall;
    logic [31:0] e_busy;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: B is granted when A is absent or B has already been refused LIMIT times in a row.
  task automatic sample();
    bit [31:0] pend;
    eb = !rst && wbb_valid && (!wba_valid || waited >= LIMIT);
    ea = !rst && wba_valid && !eb;
    hold = !rst && wba_valid && !ea;
    pend = mb;
    if (eb) pend[wbb_addr] = 1'b0;
    st = !rst && issue_valid && (pend[issue_rs1] || pend[issue_rs2] || pend[issue_rd]);
    @(negedge clk);
    chk("m_rf_we", rf_we, ea || eb);
    if (ea || eb) begin
      chk("m_rf_wa", rf_wa, eb ? wbb_addr : wba_addr);
      chk("m_rf_wd", rf_wd, eb ? wbb_data : wba_data);
    end
    chk("m_wbb_ready", wbb_ready, eb);
    chk("m_pipe_hold", pipe_hold, hold);
    chk("m_issue_stall", issue_stall, st);
    chk("m_busy_vec", busy_vec, mb);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      mb = 0; waited = 0; hc = 0; sc = 0;
    end else begin
      waited = (wbb_valid && !eb) ? waited + 1 : 0;
      if (eb) mb[wbb_addr] = 1'b0;
      if (issue_valid && !st && issue_long && issue_rd != 0) mb[issue_rd] = 1'b1;
      hc += int'(hold);
      sc += int'(st);
    end
    #1;
  endtask

  function automatic vec_t mk(logic r, logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic il,
                              logic av, logic [4:0] aa, logic [31:0] ad, logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic we, logic [4:0] wa, logic [31:0] wd, logic rdy, logic hl, logic stl, logic [31:0] bz);
    vec_t v;
    v.rst = r; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.il = il;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.e_we = we; v.e_wa = wa; v.e_wd = wd; v.e_rdy = rdy; v.e_hold = hl; v.e_stall = stl; v.e_busy = bz;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1,0,0,0,0,0, 1,3,32'h11, 0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[1]  = mk(1,0,0,0,0,0, 1,3,32'h11, 0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[2]  = mk(0,1,1,2,5,1, 0,0,0,      0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[3]  = mk(0,1,5,0,6,0, 0,0,0,      0,0,0,       0,0,0,       0,0,1, 32'h20);
    tbl[4]  = mk(0,1,5,0,6,0, 0,0,0,      1,5,32'h1234, 1,5,32'h1234, 1,0,0, 32'h20);
    tbl[5]  = mk(0,0,0,0,0,0, 0,0,0,      0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[6]  = mk(0,1,0,0,7,1, 0,0,0,      0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[7]  = mk(0,1,0,0,7,1, 0,0,0,      1,7,32'h77,  1,7,32'h77,  1,0,0, 32'h80);
    tbl[8]  = mk(0,0,0,0,0,0, 0,0,0,      0,0,0,       0,0,0,       0,0,0, 32'h80);
    tbl[9]  = mk(0,0,0,0,0,0, 0,0,0,      1,7,32'h0,   1,7,32'h0,   1,0,0, 32'h80);
    tbl[10] = mk(0,0,0,0,0,0, 0,0,0,      0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[11] = mk(0,1,0,0,0,1, 0,0,0,      0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[12] = mk(0,1,0,0,0,0, 0,0,0,      0,0,0,       0,0,0,       0,0,0, 32'h0);
    tbl[13] = mk(0,0,0,0,0,0, 1,9,32'hABCD, 0,0,0,     1,9,32'hABCD, 0,0,0, 32'h0);
    rst = 1;
    @(posedge clk); #1;
    mb = 0; waited = 0; hc = 0; sc = 0;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; issue_valid = tbl[i].iv; issue_rs1 = tbl[i].rs1; issue_rs2 = tbl[i].rs2;
      issue_rd = tbl[i].rd; issue_long = tbl[i].il; wba_valid = tbl[i].av; wba_addr = tbl[i].aa;
      wba_data = tbl[i].ad; wbb_valid = tbl[i].bv; wbb_addr = tbl[i].ba; wbb_data = tbl[i].bd;
      sample();
      chk($sformatf("t%0d_rf_we", i), rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        chk($sformatf("t%0d_rf_wa", i), rf_wa, tbl[i].e_wa);
        chk($sformatf("t%0d_rf_wd", i), rf_wd, tbl[i].e_wd);
      end
      chk($sformatf("t%0d_wbb_ready", i), wbb_ready, tbl[i].e_rdy);
      chk($sformatf("t%0d_pipe_hold", i), pipe_hold, tbl[i].e_hold);
      chk($sformatf("t%0d_issue_stall", i), issue_stall, tbl[i].e_stall);
      chk($sformatf("t%0d_busy_vec", i), busy_vec, tbl[i].e_busy);
      advance();
    end
`ifdef RF_WB_PERF_EN
    chk("stall_cnt_dir", stall_cnt, 32'd1);
`endif
    // Starvation: both sources held; A wins LIMIT cycles, then B is forced once.
    rst = 1; issue_valid = 0; wba_valid = 0; wbb_valid = 0;
    advance();
    rst = 0; wba_valid = 1; wba_addr = 2; wba_data = 32'hA; wbb_valid = 1; wbb_addr = 3; wbb_data = 32'hB;
    for (int i = 0; i < LIMIT + 2; i++) begin
      sample();
      chk($sformatf("starve%0d_ready", i), wbb_ready, i == LIMIT);
      chk($sformatf("starve%0d_hold", i), pipe_hold, i == LIMIT);
      chk($sformatf("starve%0d_wa", i), rf_wa, (i == LIMIT) ? 5'd3 : 5'd2);
      advance();
    end
`ifdef RF_WB_PERF_EN
    chk("hold_cnt_starve", hold_cnt, 32'd1);
`endif
    wba_valid = 0; wbb_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      issue_valid = $urandom_range(0, 1); issue_long = $urandom_range(0, 1);
      issue_rs1 = 5'($urandom_range(0, 7)); issue_rs2 = 5'($urandom_range(0, 7)); issue_rd = 5'($urandom_range(0, 7));
      wba_valid = ($urandom_range(0, 3) != 0); wba_addr = 5'($urandom); wba_data = $urandom;
      wbb_valid = $urandom_range(0, 1); wbb_addr = 5'($urandom_range(0, 7)); wbb_data = $urandom;
      sample();
      advance();
`ifdef RF_WB_PERF_EN
      if (i % 100 == 99) begin
        chk("hold_cnt_rand", hold_cnt, 32'(hc));
        chk("stall_cnt_rand", stall_cnt, 32'(sc));
      end
`endif
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
